// File: rtl/game_pkg.sv
// Shared game-wide types and screen constants for the pixel plotters.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SCREEN_X_MAX = 32'd159;
  localparam int SCREEN_Y_MAX = 32'd119;
  localparam int COORD_X_W    = 32'd8;
  localparam int COORD_Y_W    = 32'd7;
  localparam int COLOUR_W_DEF = 32'd3;
  localparam logic [2:0] BG_BLACK = 3'b000;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major column/row scanner over an SPR_W x SPR_H rectangle; wraps to (0,0) after the last pixel.
module rect_scan_counter #(
  parameter int SPR_W = 32'd8,
  parameter int SPR_H = 32'd8,
  localparam int CW = (SPR_W > 32'd1) ? $clog2(SPR_W) : 32'd1,
  localparam int RW = (SPR_H > 32'd1) ? $clog2(SPR_H) : 32'd1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic          col_end_s;

  assign col_end_s = (col_r == CW'(SPR_W - 32'd1));
  assign last      = col_end_s && (row_r == RW'(SPR_H - 32'd1));
  assign col       = col_r;
  assign row       = row_r;

  // Position register: advance one pixel per enabled clock
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      col_r <= '0;
      row_r <= '0;
    end else if (en) begin
      if (last) begin
        col_r <= '0;
        row_r <= '0;
      end else if (col_end_s) begin
        col_r <= '0;
        row_r <= row_r + RW'(1'b1);
      end else begin
        col_r <= col_r + CW'(1'b1);
      end
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Erase-then-redraw rectangle plotter feeding the vga_adapter pixel port, clipped to the screen.
module sprite_plotter
  import game_pkg::*;
#(
  parameter int SPR_W     = 32'd8,
  parameter int SPR_H     = 32'd8,
  parameter int X_W       = COORD_X_W,
  parameter int Y_W       = COORD_Y_W,
  parameter int COLOUR_W  = COLOUR_W_DEF,
  parameter int X_MAX     = SCREEN_X_MAX,
  parameter int Y_MAX     = SCREEN_Y_MAX,
  parameter int BG_COLOUR = int'(BG_BLACK)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                clear,
  input  logic [X_W-1:0]      new_x,
  input  logic [Y_W-1:0]      new_y,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  localparam int CW = (SPR_W > 32'd1) ? $clog2(SPR_W) : 32'd1;
  localparam int RW = (SPR_H > 32'd1) ? $clog2(SPR_H) : 32'd1;
  localparam logic [COLOUR_W-1:0] BG = COLOUR_W'(BG_COLOUR);

  state_t state_r, state_next_s, entry_s;

  logic [CW-1:0] col_s;
  logic [RW-1:0] row_s;
  logic last_s, cnt_clr_s;
  logic accept_start_s, accept_clear_s, scan_accept_s, scanning_s;

  logic [X_W-1:0]      old_x_r, pend_x_r, base_x_s, x_r, x_next_s;
  logic [Y_W-1:0]      old_y_r, pend_y_r, base_y_s, y_r, y_next_s;
  logic [COLOUR_W-1:0] pend_colour_r, pix_colour_s, colour_r, colour_next_s;
  logic                valid_r, op_start_r;
  logic                plot_r, busy_r, done_r, plot_next_s, busy_next_s, done_next_s;
  logic [X_W:0]        px_s;
  logic [Y_W:0]        py_s;

  assign accept_start_s = (state_r == IDLE) && start;
  assign accept_clear_s = (state_r == IDLE) && !start && clear;
  assign scan_accept_s  = accept_start_s || (accept_clear_s && valid_r);
  // The output register always loads the pixel the scanner points at, so the
  // accepting edge already emits pixel 0.
  assign scanning_s     = scan_accept_s || (state_r == ERASE) || (state_r == DRAW);
  assign cnt_clr_s      = (state_r == IDLE) && !scan_accept_s;

  rect_scan_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_scan (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (scanning_s),
    .col   (col_s),
    .row   (row_s),
    .last  (last_s)
  );

  // Next-state selection
  always_comb begin
    state_next_s = state_r;
    entry_s      = (accept_start_s && !valid_r) ? DRAW : ERASE;
    case (state_r)
      IDLE: begin
        if (scan_accept_s) begin
          if (last_s) begin
            state_next_s = (entry_s == ERASE && accept_start_s) ? DRAW : DONE;
          end else begin
            state_next_s = entry_s;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ERASE: begin
        if (last_s) begin
          state_next_s = op_start_r ? DRAW : DONE;
        end else begin
          state_next_s = ERASE;
        end
      end
      DRAW: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAW;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Pixel source: which rectangle origin and colour the scanner is walking
  always_comb begin
    base_x_s     = pend_x_r;
    base_y_s     = pend_y_r;
    pix_colour_s = pend_colour_r;
    case (state_r)
      IDLE: begin
        if (accept_start_s && !valid_r) begin
          base_x_s     = new_x;
          base_y_s     = new_y;
          pix_colour_s = colour_in;
        end else begin
          base_x_s     = old_x_r;
          base_y_s     = old_y_r;
          pix_colour_s = BG;
        end
      end
      ERASE: begin
        base_x_s     = old_x_r;
        base_y_s     = old_y_r;
        pix_colour_s = BG;
      end
      DRAW:    pix_colour_s = pend_colour_r;
      default: pix_colour_s = pend_colour_r;
    endcase
  end

  // Output decode with off-screen clipping
  always_comb begin
    px_s        = {1'b0, base_x_s} + (X_W + 1)'(col_s);
    py_s        = {1'b0, base_y_s} + (Y_W + 1)'(row_s);
    plot_next_s = scanning_s && (px_s <= (X_W + 1)'(X_MAX)) && (py_s <= (Y_W + 1)'(Y_MAX));
    busy_next_s = scanning_s;
    done_next_s = (state_r == DONE) || (accept_clear_s && !valid_r);
    if (scanning_s) begin
      x_next_s      = px_s[X_W-1:0];
      y_next_s      = py_s[Y_W-1:0];
      colour_next_s = pix_colour_s;
    end else begin
      x_next_s      = x_r;
      y_next_s      = y_r;
      colour_next_s = colour_r;
    end
  end

  // State, operation context and registered adapter outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      old_x_r       <= '0;
      old_y_r       <= '0;
      pend_x_r      <= '0;
      pend_y_r      <= '0;
      pend_colour_r <= '0;
      valid_r       <= 1'b0;
      op_start_r    <= 1'b0;
      plot_r        <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      x_r           <= '0;
      y_r           <= '0;
      colour_r      <= '0;
    end else begin
      state_r  <= state_next_s;
      plot_r   <= plot_next_s;
      busy_r   <= busy_next_s;
      done_r   <= done_next_s;
      x_r      <= x_next_s;
      y_r      <= y_next_s;
      colour_r <= colour_next_s;
      if (accept_start_s) begin
        pend_x_r      <= new_x;
        pend_y_r      <= new_y;
        pend_colour_r <= colour_in;
        op_start_r    <= 1'b1;
      end else if (accept_clear_s) begin
        op_start_r <= 1'b0;
      end
      if (state_r == DONE) begin
        if (op_start_r) begin
          old_x_r <= pend_x_r;
          old_y_r <= pend_y_r;
          valid_r <= 1'b1;
        end else begin
          valid_r <= 1'b0;
        end
      end
    end
  end

  assign plot   = plot_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign x      = x_r;
  assign y      = y_r;
  assign colour = colour_r;

endmodule

// File: tb/tb_sprite_plotter.sv
// Randomised and directed bench for sprite_plotter against a per-cycle expected-output queue.
module tb_sprite_plotter;

  logic       clock = 1'b0;
  logic       reset, start, clear;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [2:0] colour_in;
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int checks   = 0;
  int failures = 0;

  sprite_plotter dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .new_x     (new_x),
    .new_y     (new_y),
    .colour_in (colour_in),
    .busy      (busy),
    .done      (done),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       plot;
    logic       busy;
    logic       done;
    logic       chk;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } exp_t;

  exp_t q[$];
  exp_t exp_cur;
  bit   have_exp = 1'b0;
  bit   m_valid  = 1'b0;
  int   m_old_x  = 0;
  int   m_old_y  = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // One expected cycle per pixel of an 8x8 rectangle, row-major, clipped to 160x120
  task automatic push_rect(input int bx, input int by, input logic [2:0] c);
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        e.plot   = ((bx + k) <= 159) && ((by + r) <= 119);
        e.busy   = 1'b1;
        e.done   = 1'b0;
        e.chk    = 1'b1;
        e.x      = 8'((bx + k) % 256);
        e.y      = 7'((by + r) % 128);
        e.colour = c;
        q.push_back(e);
      end
    end
  endtask

  task automatic push_done();
    exp_t e;
    e      = '0;
    e.done = 1'b1;
    q.push_back(e);
  endtask

  function automatic int count_plots();
    int n;
    n = int'(exp_cur.plot);
    foreach (q[i]) n += int'(q[i].plot);
    return n;
  endfunction

  // Reference model: requests are only taken when nothing is outstanding
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        q.delete();
        m_valid     = 1'b0;
        exp_cur     = '0;
        exp_cur.chk = 1'b1;
      end else begin
        if (q.size() == 0) begin
          if (start) begin
            if (m_valid) push_rect(m_old_x, m_old_y, 3'b000);
            push_rect(int'(new_x), int'(new_y), colour_in);
            push_done();
            m_old_x = int'(new_x);
            m_old_y = int'(new_y);
            m_valid = 1'b1;
          end else if (clear) begin
            if (m_valid) push_rect(m_old_x, m_old_y, 3'b000);
            push_done();
            m_valid = 1'b0;
          end
        end
        if (q.size() != 0) exp_cur = q.pop_front();
        else exp_cur = '0;
      end
      have_exp = 1'b1;
    end
  end

  // Compare process, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clock);
      if (have_exp) begin
        check("plot", int'(plot), int'(exp_cur.plot));
        check("busy", int'(busy), int'(exp_cur.busy));
        check("done", int'(done), int'(exp_cur.done));
        if (exp_cur.chk) begin
          check("x", int'(x), int'(exp_cur.x));
          check("y", int'(y), int'(exp_cur.y));
          check("colour", int'(colour), int'(exp_cur.colour));
        end
      end
    end
  end

  task automatic pulse(input logic st, input logic cl, input int nx, input int ny, input logic [2:0] c);
    @(posedge clock);
    #1;
    start     = st;
    clear     = cl;
    new_x     = 8'(nx);
    new_y     = 7'(ny);
    colour_in = c;
    @(posedge clock);
    #1;
    start = 1'b0;
    clear = 1'b0;
  endtask

  // Cycles from the accepting edge until done is seen
  task automatic wait_done(input string name, input int expv);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 400);
    check(name, n, expv);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(name, int'(n < 400), 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    new_x = 8'd0; new_y = 7'd0; colour_in = 3'b000;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    pulse(1'b1, 1'b0, 10, 20, 3'b100);
    check("pin_len1", q.size(), 64);
    check("pin_x0", int'(exp_cur.x), 10);
    check("pin_c0", int'(exp_cur.colour), 4);
    check("pin_x63", int'(q[62].x), 17);
    check("pin_y63", int'(q[62].y), 27);
    wait_done("lat_first_draw", 65);

    pulse(1'b1, 1'b0, 12, 20, 3'b010);
    check("pin_len2", q.size(), 128);
    check("pin_erase_c", int'(exp_cur.colour), 0);
    check("pin_draw_x0", int'(q[63].x), 12);
    check("pin_draw_c0", int'(q[63].colour), 2);
    wait_done("lat_move", 129);

    pulse(1'b0, 1'b1, 0, 0, 3'b000);
    wait_done("lat_clear", 65);
    pulse(1'b0, 1'b1, 0, 0, 3'b000);
    wait_done("lat_clear_empty", 1);

    pulse(1'b1, 1'b0, 156, 118, 3'b111);
    check("pin_clip_plots", count_plots(), 8);
    wait_done("lat_clip", 65);

    pulse(1'b1, 1'b0, 30, 40, 3'b011);
    repeat (79) @(negedge clock);
    pulse(1'b1, 1'b0, 70, 70, 3'b101);
    wait_idle("busy_ignore_bound");
    pulse(1'b0, 1'b1, 0, 0, 3'b000);
    wait_done("lat_clear2", 65);
    pulse(1'b0, 1'b1, 0, 0, 3'b000);
    wait_done("lat_clear2_empty", 1);

    pulse(1'b1, 1'b0, 50, 50, 3'b001);
    wait_done("lat_pre_abort", 65);
    pulse(1'b1, 1'b0, 52, 50, 3'b110);
    repeat (94) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_plot", int'(plot), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    pulse(1'b1, 1'b0, 60, 60, 3'b010);
    wait_done("lat_after_abort", 65);

    pulse(1'b1, 1'b1, 61, 61, 3'b100);
    wait_done("lat_start_and_clear", 129);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      #1;
      reset     = ($urandom_range(0, 499) == 0);
      start     = ($urandom_range(0, 29) == 0);
      clear     = ($urandom_range(0, 39) == 0);
      new_x     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(140, 255)) : 8'($urandom);
      new_y     = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(105, 127)) : 7'($urandom);
      colour_in = 3'($urandom);
    end
    @(posedge clock);
    #1;
    reset = 1'b0; start = 1'b0; clear = 1'b0;
    wait_idle("drain_bound");
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
